// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared widths and command/tag types for the SRAM round-robin arbiter
package sram_arb_pkg;

  localparam int SRAM_ADDR_W = 10;
  localparam int SRAM_DATA_W = 32;

  // Tags are sized for the largest supported requester count so the type
  // does not depend on any one instance's NUM_REQ.
  localparam int MAX_REQ = 4;
  localparam int OWNER_W = $clog2(MAX_REQ);

  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] bm;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_cmd_t;

  typedef struct packed {
    logic               valid;
    logic               we;
    logic [OWNER_W-1:0] owner;
  } sram_tag_t;

endpackage

// File: rtl/sram_rr_arbiter_if.sv
// rtl/sram_rr_arbiter_if.sv - requester command/response bus for the SRAM arbiter
interface sram_rr_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = SRAM_ADDR_W,
  parameter int DATA_W  = SRAM_DATA_W
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_bm;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic                      rsp_we;
  logic [DATA_W-1:0]         rsp_rdata;

  // Requester side
  modport master (
    output req_valid, req_we, req_addr, req_bm, req_wdata,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_we, req_addr, req_bm, req_wdata,
    output req_ready, rsp_valid, rsp_we, rsp_rdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant with pointer advanced past each winner
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_update,
  output logic [NUM_REQ-1:0] o_grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_next;
  logic             w_found;

  // Search from the pointer upward, then wrap to the low indices below it
  always_comb begin
    o_grant    = '0;
    w_ptr_next = r_ptr;
    w_found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && (i >= int'(r_ptr)) && i_req[i]) begin
        w_found    = 1'b1;
        o_grant[i] = 1'b1;
        w_ptr_next = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
    // Any requester still found here lies below the pointer (wrap-around)
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[i]) begin
        w_found    = 1'b1;
        o_grant[i] = 1'b1;
        w_ptr_next = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  // Pointer moves only when a grant is actually taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_update) begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - shares one 1024x32 SRAM macro among NUM_REQ requesters
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = SRAM_ADDR_W,
  parameter int DATA_W  = SRAM_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  sram_rr_arbiter_if.slave    bus,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_bm,
  output logic [DATA_W-1:0]   sram_din,
  output logic                sram_wen,
  output logic                sram_ren,
  output logic                sram_men,
  input  logic [DATA_W-1:0]   sram_dout
);

  logic [NUM_REQ-1:0] w_grant;
  logic               w_take;
  sram_cmd_t          w_cmd;
  logic [OWNER_W-1:0] w_owner;

  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_bm;
  logic [DATA_W-1:0]  r_din;
  logic               r_wen;
  logic               r_ren;
  sram_tag_t          r_s1_tag;
  sram_tag_t          r_s2_tag;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk      (clk),
    .rst      (rst),
    .i_req    (bus.req_valid),
    .i_update (w_take),
    .o_grant  (w_grant)
  );

  // No back-pressure downstream, so every grant outside reset is a transfer
  assign bus.req_ready = rst ? '0 : w_grant;
  assign w_take        = (|w_grant) & ~rst;

  // Select the granted requester's payload from the flattened buses
  always_comb begin
    w_cmd   = '0;
    w_owner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_cmd.we    = bus.req_we[i];
        w_cmd.addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        w_cmd.bm    = bus.req_bm[i*DATA_W +: DATA_W];
        w_cmd.wdata = bus.req_wdata[i*DATA_W +: DATA_W];
        w_owner     = OWNER_W'(i);
      end
    end
  end

  // Stage 1: register the accepted command onto the SRAM pins; data pins hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_bm     <= '0;
      r_din    <= '0;
      r_wen    <= 1'b0;
      r_ren    <= 1'b0;
      r_s1_tag <= '0;
    end else begin
      r_wen          <= w_take & w_cmd.we;
      r_ren          <= w_take & ~w_cmd.we;
      r_s1_tag.valid <= w_take;
      r_s1_tag.we    <= w_cmd.we;
      r_s1_tag.owner <= w_owner;
      if (w_take) begin
        r_addr <= w_cmd.addr;
        r_bm   <= w_cmd.bm;
        r_din  <= w_cmd.wdata;
      end
    end
  end

  // Stage 2: tag follows the access by one cycle, aligned with SRAM read data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_tag <= '0;
    end else begin
      r_s2_tag <= r_s1_tag;
    end
  end

  assign sram_addr = r_addr;
  assign sram_bm   = r_bm;
  assign sram_din  = r_din;
  assign sram_wen  = r_wen;
  assign sram_ren  = r_ren;
  assign sram_men  = r_wen | r_ren;

  // Decode the stage-2 owner into the one-hot response pulse
  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_s2_tag.valid && (r_s2_tag.owner == OWNER_W'(i))) begin
        bus.rsp_valid[i] = 1'b1;
      end
    end
  end

  assign bus.rsp_we    = r_s2_tag.valid & r_s2_tag.we;
  assign bus.rsp_rdata = (r_s2_tag.valid && !r_s2_tag.we) ? sram_dout : '0;

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
Shares one IHP_SRAM_1024x32_wrapper macro between NUM_REQ requesters, such as TT project wrappers or fabric user logic, using round-robin arbitration.
- Each requester issues read/write commands over a valid/ready handshake.
- Accepted commands are registered into the SRAM drive pins; the arbiter can accept one command per cycle.
- Read data and write acks return on a per-requester response pulse at fixed latency.
- Sits in the user-design top between the requesters and the SRAM wrapper, driving all SRAM pins.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 10, SRAM word address width.
- DATA_W, 32, SRAM data and bit-mask width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  command valid per requester.
- req_ready  out  NUM_REQ  command accepted this cycle (one-hot or zero).
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  word address; requester i in slice i.
- req_bm  in  NUM_REQ*DATA_W  per-bit write mask (1 = write bit).
- req_wdata  in  NUM_REQ*DATA_W  write data.
- rsp_valid  out  NUM_REQ  one-cycle response pulse to the owning requester.
- rsp_we  out  1  response is a write ack.
- rsp_rdata  out  DATA_W  read data (shared bus); 0 for write acks.
- sram_addr  out  ADDR_W  to SRAM ADDR.
- sram_bm  out  DATA_W  to SRAM BM.
- sram_din  out  DATA_W  to SRAM DIN.
- sram_wen  out  1  to SRAM WEN, active-high.
- sram_ren  out  1  to SRAM REN, active-high.
- sram_men  out  1  to SRAM MEN; equals sram_wen | sram_ren.
- sram_dout  in  DATA_W  from SRAM DOUT; valid the cycle after the REN cycle.

Behaviour:
- Reset values: sram_* outputs 0, rsp_valid 0, rsp_we 0, rsp_rdata 0, priority pointer 0, pipeline valid bits 0.
- req_ready is 0 while rst is high.

Handshake:
- A transfer occurs when req_valid[i] && req_ready[i].
- A requester holds valid and its payload stable until ready.
- Valid may drop only after a transfer.
- req_ready is combinational from req_valid and the pointer; it has no combinational path from sram_dout.

Arbitration:
- Search starts at the pointer p and proceeds upward modulo NUM_REQ; the first valid requester g is granted.
- On a grant, p <= (g+1) mod NUM_REQ.
- With no grant, p holds.
- The response path has no back-pressure, so a grant is issued every cycle any valid request exists.

Pipeline (transfer in cycle N):
- N+1: stage-1 register drives sram_addr/bm/din and sram_wen = we, sram_ren = ~we, sram_men = 1, plus a tag (owner id and we).
- N+1 with no new transfer: all SRAM enables are 0; addr/bm/din hold their previous values.
- N+2: stage-2 asserts rsp_valid[owner] for one cycle and sets rsp_we = we.
- N+2 data: rsp_rdata = sram_dout for reads and 0 for writes.
- Latency is 2 cycles from handshake to response; throughput is 1 command per cycle.

Ordering and hazards:
- Commands reach the SRAM in grant order.
- A read granted the cycle after a write to the same address returns the new data; the macro sequences accesses, so no bypass is needed.

Reset mid-operation:
- rst clears both stages; in-flight commands are dropped and produce no rsp_valid.
- The first grant after release goes to requester 0 if it is valid.

Invalid inputs:
- req_addr bits beyond ADDR_W do not exist.
- A payload change while valid is high without ready is a protocol violation; the bench asserts on it and no recovery is defined.

Decomposition:
- Package sram_arb_pkg holds:
  - SRAM_ADDR_W = 10 and SRAM_DATA_W = 32.
  - typedef sram_cmd_t {we, addr, bm, wdata}.
  - typedef sram_tag_t {valid, we, owner[$clog2(NUM_REQ)]}.
- Sub-module rr_arbiter (param NUM_REQ): req vector in; one-hot grant out; pointer register with update-on-grant input.
- Reusable for other shared fabric macros.

Test Plan:
1. req0 writes addr 0x005, data 0xDEADBEEF, bm 0xFFFFFFFF; then reads 0x005 -> rsp_valid[0] with rsp_we = 1 two cycles after the write handshake; read rsp_valid[0] two cycles after the read handshake with rsp_rdata = 0xDEADBEEF.
2. req0 and req1 both valid continuously, reading 0x010 / 0x020 after reset -> grants 0,1,0,1 with one per cycle; rsp_valid alternates with matching data.
3. Write 0xFFFFFFFF to 0x3FF, then write 0x00000000 with bm 0x0000FF00, then read -> rsp_rdata = 0xFFFF00FF.
4. Only req1 valid for 3 cycles, then both valid -> req0 granted next (pointer = 0 after the req1 grant).
5. Handshake a read at cycle N, assert rst at N+1 -> no rsp_valid at N+2; sram_men = 0; after release both valid -> req0 granted first.
6. Write 0x12345678 to 0x040 by req1, read 0x040 by req0 in the next cycle -> req0 rsp_rdata = 0x12345678.
